// File: rtl/servo_pwm_driver_if.sv
// Command link between the ball position controller and servo_pwm_driver.
// The controller drives command/cmd_valid; the driver reports dropped commands.
interface servo_pwm_driver_if;
    logic [11:0] command;
    logic        cmd_valid;
    logic        cmd_drop;

    modport master (output command, output cmd_valid, input  cmd_drop);
    modport slave  (input  command, input  cmd_valid, output cmd_drop);
endinterface

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator for one plate axis; commands are applied only at frame wraps.
// Optional macro SERVO_SLEW_LIMIT_EN limits the per-frame change of the pulse high time.
module servo_pwm_driver #(
    parameter int unsigned FRAME_CYCLES = 2_000_000,
    parameter int unsigned MIN_PULSE    = 100_000,
    parameter int unsigned MAX_PULSE    = 200_000,
    parameter int unsigned CMD_LO       = 0,
    parameter int unsigned CMD_HI       = 4095,
    parameter int unsigned SLEW_STEP    = 2_000
) (
    input  logic               clock,
    input  logic               reset,
    servo_pwm_driver_if.slave  cmd_bus,
    output logic               pwm,
    output logic               frame_tick,
    output logic [31:0]        pulse_width
);

    localparam int unsigned SPAN   = MAX_PULSE - MIN_PULSE;
    localparam int unsigned PW     = 12 + $clog2(SPAN + 1);
    localparam int unsigned CW     = $clog2(FRAME_CYCLES);
    localparam int          LO_S   = int'(CMD_LO);
    localparam int          HI_S   = int'(CMD_HI);
    localparam logic [31:0] CENTRE = 32'(MIN_PULSE + ((64'(2048) * 64'(SPAN)) >> 12));

    if (!(MIN_PULSE < MAX_PULSE && MAX_PULSE < FRAME_CYCLES &&
          CMD_LO <= CMD_HI && CMD_HI <= 4095 && SLEW_STEP > 0)) begin : g_param_check
        $error("servo_pwm_driver: inconsistent timing parameters");
    end

    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          pwm_q, pwm_d;
    logic          cv_q, cv_d;
    logic [11:0]   cmd_q, cmd_d;
    logic          cap_v_q, cap_v_d;
    logic [11:0]   clamp_q, clamp_d;
    logic          s1_v_q, s1_v_d;
    logic [PW-1:0] prod_q, prod_d;
    logic          s2_v_q, s2_v_d;
    logic          pending_q, pending_d;
    logic          cmd_drop_q, cmd_drop_d;
    logic [31:0]   target_q, target_d;
    logic          ready_q, ready_d;
    logic [31:0]   pulse_width_q, pulse_width_d;

    logic          last;
    logic          cap;
    int            cmd_s;
    logic [31:0]   tgt_new;
    logic [31:0]   eff_tgt;
    logic          eff_rdy;

    always_comb begin
        last        = (frame_cnt_q == CW'(FRAME_CYCLES - 1));
        frame_cnt_d = last ? '0 : frame_cnt_q + CW'(1);
        pwm_d       = (32'(frame_cnt_q) < pulse_width_q);

        cap        = cmd_bus.cmd_valid & ~cv_q;
        cv_d       = cmd_bus.cmd_valid;
        cmd_d      = cap ? cmd_bus.command : cmd_q;
        cap_v_d    = cap;
        cmd_drop_d = cap & pending_q;

        cmd_s = int'(cmd_q);
        if (cmd_s < LO_S) begin
            clamp_d = 12'(CMD_LO);
        end else if (cmd_s > HI_S) begin
            clamp_d = 12'(CMD_HI);
        end else begin
            clamp_d = cmd_q;
        end
        s1_v_d  = cap_v_q;
        prod_d  = PW'(clamp_q) * PW'(SPAN);
        s2_v_d  = s1_v_q;
        tgt_new = 32'(MIN_PULSE) + 32'(prod_q >> 12);

        // Pending only clears once the newest capture leaves the pipeline.
        if (cap) begin
            pending_d = 1'b1;
        end else if (s2_v_q && !cap_v_q && !s1_v_q) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // A result finishing in the wrap cycle is forwarded so it still makes this frame.
        eff_rdy       = ready_q | s2_v_q;
        eff_tgt       = s2_v_q ? tgt_new : target_q;
        target_d      = eff_tgt;
        ready_d       = eff_rdy;
        pulse_width_d = pulse_width_q;
        if (last && eff_rdy) begin
`ifdef SERVO_SLEW_LIMIT_EN
            if (eff_tgt > pulse_width_q) begin
                pulse_width_d = (eff_tgt - pulse_width_q > 32'(SLEW_STEP)) ?
                                pulse_width_q + 32'(SLEW_STEP) : eff_tgt;
            end else begin
                pulse_width_d = (pulse_width_q - eff_tgt > 32'(SLEW_STEP)) ?
                                pulse_width_q - 32'(SLEW_STEP) : eff_tgt;
            end
            ready_d = (pulse_width_d != eff_tgt);
`else
            pulse_width_d = eff_tgt;
            ready_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            pwm_q         <= 1'b0;
            cv_q          <= 1'b0;
            cmd_q         <= '0;
            cap_v_q       <= 1'b0;
            clamp_q       <= '0;
            s1_v_q        <= 1'b0;
            prod_q        <= '0;
            s2_v_q        <= 1'b0;
            pending_q     <= 1'b0;
            cmd_drop_q    <= 1'b0;
            target_q      <= CENTRE;
            ready_q       <= 1'b0;
            pulse_width_q <= CENTRE;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            pwm_q         <= pwm_d;
            cv_q          <= cv_d;
            cmd_q         <= cmd_d;
            cap_v_q       <= cap_v_d;
            clamp_q       <= clamp_d;
            s1_v_q        <= s1_v_d;
            prod_q        <= prod_d;
            s2_v_q        <= s2_v_d;
            pending_q     <= pending_d;
            cmd_drop_q    <= cmd_drop_d;
            target_q      <= target_d;
            ready_q       <= ready_d;
            pulse_width_q <= pulse_width_d;
        end
    end

    assign pwm              = pwm_q;
    assign frame_tick       = last;
    assign pulse_width      = pulse_width_q;
    assign cmd_bus.cmd_drop = cmd_drop_q;

endmodule
